// File: rtl/dmem_if.sv
// Data-memory port bundle between the CPU requester and the memory responder.
// Holds the request handshake with its payload and the response handshake.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_op;
  logic        req_ext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_op, req_ext, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_op, req_ext, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Slow data-memory responder: one outstanding load/store at a time, a
// configurable number of wait states, and byte/halfword/word lanes with
// sign or zero extension on loads.
// Optional build macro: DMEM_ALIGN_CHECK_EN enables misalignment detection
// (suppressed access plus resp_err); without it, offending low address bits
// are simply ignored.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus,
  output logic  busy
);

  localparam int          AW      = ADDR_W + 2;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [1:0]      op_q, op_d;
  logic            ext_q, ext_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            busy_q, busy_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [2**ADDR_W];

  logic            src_write_s;
  logic [1:0]      src_op_s;
  logic            src_ext_s;
  logic [AW-1:0]   src_addr_s;
  logic [31:0]     src_wdata_s;
  logic [ADDR_W-1:0] idx_s;
  logic [31:0]     mem_word_s;
  logic            misalign_s;
  logic            enter_resp_s;
  logic            wr_en_s;
  logic [31:0]     rdata_nxt_s;
  logic            unused_addr_s;

  // Selected lane moved to bit 0 and extended to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] op,
                                               input logic ext, input logic [1:0] lo);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    case (op)
      2'b01:   r = ext ? {{16{h[15]}}, h} : {16'h0000, h};
      2'b10:   r = ext ? {{24{b[7]}}, b}  : {24'h000000, b};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store data merged into the existing word; unselected bytes are kept.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] op, input logic [1:0] lo);
    logic [31:0] r;
    r = word;
    case (op)
      2'b01: begin
        if (lo[1]) r[31:16] = wdata[15:0];
        else       r[15:0]  = wdata[15:0];
      end
      2'b10: begin
        case (lo)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          2'b11:   r[31:24] = wdata[7:0];
          default: r = word;
        endcase
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Access fields come straight from the bus on the accept edge, else from the latch.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_write_s = bus.req_write;
      src_op_s    = bus.req_op;
      src_ext_s   = bus.req_ext;
      src_addr_s  = bus.req_addr[AW-1:0];
      src_wdata_s = bus.req_wdata;
    end else begin
      src_write_s = write_q;
      src_op_s    = op_q;
      src_ext_s   = ext_q;
      src_addr_s  = addr_q;
      src_wdata_s = wdata_q;
    end
  end

  assign unused_addr_s = ^bus.req_addr[31:AW];
  assign idx_s         = src_addr_s[AW-1:2];
  assign mem_word_s    = mem[idx_s];

`ifdef DMEM_ALIGN_CHECK_EN
  // Halfwords need addr[0]=0; words (and the reserved size) need addr[1:0]=0.
  always_comb begin
    case (src_op_s)
      2'b01:   misalign_s = src_addr_s[0];
      2'b10:   misalign_s = 1'b0;
      default: misalign_s = (src_addr_s[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign enter_resp_s = ((state_q == ST_IDLE) && bus.req_valid && (WAIT_LD == 4'd0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign wr_en_s      = enter_resp_s && src_write_s && !misalign_s;
  assign rdata_nxt_s  = (src_write_s || misalign_s) ? 32'd0
                        : load_extract(mem_word_s, src_op_s, src_ext_s, src_addr_s[1:0]);

  // Storage array: single commit on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[idx_s] <= store_merge(mem_word_s, src_wdata_s, src_op_s, src_addr_s[1:0]);
    end
  end

  // Next-state, latch and registered-output computation for the handshake FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    op_d    = op_q;
    ext_d   = ext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          op_d    = bus.req_op;
          ext_d   = bus.req_ext;
          addr_d  = bus.req_addr[AW-1:0];
          wdata_d = bus.req_wdata;
          if (WAIT_LD == 4'd0) begin
            state_d = ST_RESP;
            rdata_d = rdata_nxt_s;
            err_d   = misalign_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // cnt holds the wait cycles still to run before the response edge.
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = rdata_nxt_s;
          err_d   = misalign_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      op_q         <= 2'b00;
      ext_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      op_q         <= op_d;
      ext_q        <= ext_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=2, ADDR_W=10).
module tb_dmem_responder;
  logic clk;
  logic rst_n;
  logic busy;
  int   total;
  int   bad;

  dmem_if bus_if ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk  (clk),
    .rst  (rst_n),
    .bus  (bus_if),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction; returns the response and the number of edges from
  // acceptance until resp_valid was first seen (40 means it never came).
  task automatic access(input logic wr, input logic [1:0] op, input logic ext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic got;
    @(negedge clk);
    bus_if.req_write  = wr;
    bus_if.req_op     = op;
    bus_if.req_ext    = ext;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.req_valid  = 1'b1;
    bus_if.resp_ready = 1'b0;
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #1 if (bus_if.resp_valid) got = 1'b1;
    end
    rdata = bus_if.resp_rdata;
    err   = bus_if.resp_err;
    @(negedge clk) bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus_if.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", bus_if.req_ready); end
    total++; if (bus_if.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got %b want 0", bus_if.resp_valid); end
    total++; if (bus_if.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", bus_if.resp_rdata); end
    total++; if (bus_if.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus_if.resp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL store_latency got %0d want 3", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata got %h want 00000000", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got %b want 0", er); end
    access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL load_latency got %0d want 3", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_word got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err got %b want 0", er); end
  endtask

  task automatic test_load_ext();
    logic [1:0]  ops [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    logic        exts[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] adrs[6] = '{32'h20, 32'h20, 32'h20, 32'h22, 32'h21, 32'h20};
    logic [31:0] exps[6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0,
                             32'h00000000, 32'hFFFFFF80, 32'h000080F0};
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 2'b00, 1'b0, 32'h20, 32'h000080F0, rd, er, lat);
    for (int i = 0; i < 6; i++) begin
      access(1'b0, ops[i], exts[i], adrs[i], 32'h0, rd, er, lat);
      total++;
      if (rd !== exps[i]) begin bad++; $display("FAIL load_ext[%0d] got %h want %h", i, rd, exps[i]); end
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 2'b00, 1'b0, 32'h30, 32'h11223344, rd, er, lat);
    access(1'b1, 2'b10, 1'b0, 32'h31, 32'hFFFFFFAA, rd, er, lat);
    access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h1122AA44) begin bad++; $display("FAIL store_byte got %h want 1122aa44", rd); end
    access(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234BEEF, rd, er, lat);
    access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hBEEFAA44) begin bad++; $display("FAIL store_half got %h want beefaa44", rd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int lat; logic got;
    @(negedge clk);
    bus_if.req_write = 1'b0; bus_if.req_op = 2'b00; bus_if.req_ext = 1'b0;
    bus_if.req_addr = 32'h30; bus_if.req_valid = 1'b1; bus_if.resp_ready = 1'b0;
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    got = 1'b0; lat = 0;
    while (!got && lat < 40) begin @(posedge clk); lat++; #1 if (bus_if.resp_valid) got = 1'b1; end
    total++; if (lat !== 3) begin bad++; $display("FAIL stall_latency got %0d want 3", lat); end
    // A competing store is offered during the stall and must be ignored.
    @(negedge clk);
    bus_if.req_write = 1'b1; bus_if.req_wdata = 32'h0BADF00D; bus_if.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (bus_if.resp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got %b want 1", c, bus_if.resp_valid); end
      total++; if (bus_if.resp_rdata !== 32'hBEEFAA44) begin bad++; $display("FAIL stall_rdata[%0d] got %h want beefaa44", c, bus_if.resp_rdata); end
      total++; if (bus_if.req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready[%0d] got %b want 0", c, bus_if.req_ready); end
    end
    @(negedge clk);
    bus_if.resp_ready = 1'b1; bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    bus_if.resp_ready = 1'b0;
    total++; if (bus_if.resp_valid !== 1'b0) begin bad++; $display("FAIL release_valid got %b want 0", bus_if.resp_valid); end
    total++; if (bus_if.req_ready !== 1'b1) begin bad++; $display("FAIL release_req_ready got %b want 1", bus_if.req_ready); end
    total++; if (bus_if.resp_rdata !== 32'h0) begin bad++; $display("FAIL release_rdata got %h want 0", bus_if.resp_rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got %b want 0", busy); end
    access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hBEEFAA44) begin bad++; $display("FAIL stall_ignored_store got %h want beefaa44", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, lat);
    @(negedge clk);
    bus_if.req_write = 1'b1; bus_if.req_op = 2'b00; bus_if.req_addr = 32'h40;
    bus_if.req_wdata = 32'h12345678; bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy got %b want 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus_if.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_req_ready got %b want 1", bus_if.req_ready); end
    total++; if (bus_if.resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_resp_valid got %b want 0", bus_if.resp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL midrst_discard got %h want cafef00d", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    logic        exp_err;
    logic [31:0] exp_word;
    logic [31:0] exp_half;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_word = 32'hCAFEF00D; exp_half = 32'h00000000;
`else
    exp_err = 1'b0; exp_word = 32'h12345678; exp_half = 32'h0000BEEF;
`endif
    access(1'b1, 2'b00, 1'b0, 32'h41, 32'h12345678, rd, er, lat);
    total++; if (er !== exp_err) begin bad++; $display("FAIL mis_store_err got %b want %b", er, exp_err); end
    total++; if (lat !== 3) begin bad++; $display("FAIL mis_latency got %0d want 3", lat); end
    access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, rd, er, lat);
    total++; if (rd !== exp_word) begin bad++; $display("FAIL mis_store_word got %h want %h", rd, exp_word); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL aligned_err got %b want 0", er); end
    access(1'b0, 2'b01, 1'b0, 32'h33, 32'h0, rd, er, lat);
    total++; if (rd !== exp_half) begin bad++; $display("FAIL mis_half got %h want %h", rd, exp_half); end
    total++; if (er !== exp_err) begin bad++; $display("FAIL mis_half_err got %b want %b", er, exp_err); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 2'b00, 1'b0, 32'h00001010, 32'h5555AAAA, rd, er, lat);
    access(1'b0, 2'b00, 1'b0, 32'h00000010, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h5555AAAA) begin bad++; $display("FAIL wrap_low got %h want 5555aaaa", rd); end
    access(1'b0, 2'b00, 1'b0, 32'hFFFFF010, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h5555AAAA) begin bad++; $display("FAIL wrap_high got %h want 5555aaaa", rd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_op     = 2'b00;
    bus_if.req_ext    = 1'b0;
    bus_if.req_addr   = 32'h0;
    bus_if.req_wdata  = 32'h0;
    bus_if.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word();
    test_load_ext();
    test_store_lanes();
    test_stall();
    test_reset_mid();
    test_misaligned();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
